// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache with same-cycle hits and a single-request line fill.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module instruction_cache_controller #(
   parameter int NUM_LINES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fetchPC,
   input  logic        fetchRequest,
   input  logic        flush,
   output logic [31:0] instruction,
   output logic        instructionValid,
   output logic        stall,
   output logic [31:0] passedPC,
   output logic        instructionRequest,
   input  logic [63:0] cacheData,
   input  logic        receivedInstruction
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hitCount,
   output logic [31:0] missCount
`endif
);

   localparam int IDX  = $clog2(NUM_LINES);
   localparam int TAGW = 29 - IDX;

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT} CacheState;

   CacheState            state;
   logic [NUM_LINES-1:0] validBits;
   logic [TAGW-1:0]      tagMem  [NUM_LINES];
   logic [63:0]          dataMem [NUM_LINES];
   logic [28:0]          missLine;
   logic                 missWord;
   logic                 flushPending;

   logic [IDX-1:0]       fetchIndex;
   logic [TAGW-1:0]      fetchTag;
   logic [IDX-1:0]       fillIndex;
   logic [TAGW-1:0]      fillTag;
   logic [63:0]          selectedLine;
   logic                 hit;
   logic                 idleHit;
   logic                 missDetect;
   logic                 fillWrite;
   logic                 unusedPcBits;

   assign fetchIndex   = fetchPC[3+IDX-1:3];
   assign fetchTag     = fetchPC[31:3+IDX];
   assign fillIndex    = missLine[IDX-1:0];
   assign fillTag      = missLine[28:IDX];
   assign selectedLine = dataMem[fetchIndex];
   assign hit          = validBits[fetchIndex] && (tagMem[fetchIndex] == fetchTag);
   assign idleHit      = (state == IDLE) && fetchRequest && hit;
   assign missDetect   = (state == IDLE) && fetchRequest && !hit;
   assign fillWrite    = (state == WAIT) && receivedInstruction;
   assign unusedPcBits = ^fetchPC[1:0];

   // Hits are served straight from the array; fills forward the word chosen by the latched miss address.
   always_comb begin
      instructionValid = 1'b0;
      instruction      = 32'h0;
      if (idleHit) begin
         instructionValid = 1'b1;
         instruction      = fetchPC[2] ? selectedLine[31:0] : selectedLine[63:32];
      end else if (fillWrite) begin
         instructionValid = 1'b1;
         instruction      = missWord ? cacheData[31:0] : cacheData[63:32];
      end
   end

   assign stall = fetchRequest && !instructionValid;

   // Miss FSM. A flush seen while a fill is outstanding leaves the arriving line invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         validBits          <= '0;
         instructionRequest <= 1'b0;
         passedPC           <= 32'h0;
         missLine           <= '0;
         missWord           <= 1'b0;
         flushPending       <= 1'b0;
      end else begin
         instructionRequest <= 1'b0;
         if (flush) validBits <= '0;
         case (state)
            IDLE: begin
               flushPending <= 1'b0;
               if (missDetect) begin
                  missLine           <= fetchPC[31:3];
                  missWord           <= fetchPC[2];
                  passedPC           <= {fetchPC[31:3], 3'b000};
                  instructionRequest <= 1'b1;
                  state              <= REQUEST;
               end
            end
            REQUEST: begin
               if (flush) flushPending <= 1'b1;
               state <= WAIT;
            end
            WAIT: begin
               if (flush) flushPending <= 1'b1;
               if (receivedInstruction) begin
                  if (!(flush || flushPending)) validBits[fillIndex] <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line data and tags carry no reset; the valid bits alone decide whether they are trusted.
   always_ff @(posedge clk) begin
      if (fillWrite) begin
         dataMem[fillIndex] <= cacheData;
         tagMem[fillIndex]  <= fillTag;
      end
   end

`ifdef ICACHE_STATS_EN
   // Counters survive flush and wrap naturally at 32 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hitCount  <= 32'h0;
         missCount <= 32'h0;
      end else begin
         if (idleHit)    hitCount  <= hitCount + 32'd1;
         if (missDetect) missCount <= missCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed, table-driven bench for instruction_cache_controller (NUM_LINES=8), with
// hand sequences for reset during a miss and the optional statistics counters.
module tb_instruction_cache_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetchPC;
   logic        fetchRequest;
   logic        flush;
   logic [31:0] instruction;
   logic        instructionValid;
   logic        stall;
   logic [31:0] passedPC;
   logic        instructionRequest;
   logic [63:0] cacheData;
   logic        receivedInstruction;
`ifdef ICACHE_STATS_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        req;
      logic [31:0] pc;
      logic        fl;
      logic        recv;
      logic [63:0] data;
      logic        expValid;
      logic [31:0] expInstr;
      logic        expReq;
      logic [31:0] expPassed;
   } TestVector;

   TestVector vectors[$];

   instruction_cache_controller #(.NUM_LINES(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .fetchPC             (fetchPC),
      .fetchRequest        (fetchRequest),
      .flush               (flush),
      .instruction         (instruction),
      .instructionValid    (instructionValid),
      .stall               (stall),
      .passedPC            (passedPC),
      .instructionRequest  (instructionRequest),
      .cacheData           (cacheData),
      .receivedInstruction (receivedInstruction)
`ifdef ICACHE_STATS_EN
      ,
      .hitCount            (hitCount),
      .missCount           (missCount)
`endif
   );

   always #5 clk = ~clk;

   task automatic addVector(input string name, input logic req, input logic [31:0] pc,
                            input logic fl, input logic recv, input logic [63:0] data,
                            input logic expValid, input logic [31:0] expInstr,
                            input logic expReq, input logic [31:0] expPassed);
      TestVector v;
      v.name = name; v.req = req; v.pc = pc; v.fl = fl; v.recv = recv; v.data = data;
      v.expValid = expValid; v.expInstr = expInstr; v.expReq = expReq; v.expPassed = expPassed;
      vectors.push_back(v);
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic fl,
                                input logic recv, input logic [63:0] data);
      @(posedge clk);
      #1;
      fetchRequest        = req;
      fetchPC             = pc;
      flush               = fl;
      receivedInstruction = recv;
      cacheData           = data;
      #3;
   endtask

   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expInstr,
                              input logic expReq, input logic [31:0] expPassed);
      compare({name, ".instructionValid"}, {31'b0, instructionValid}, {31'b0, expValid});
      compare({name, ".instruction"}, instruction, expInstr);
      compare({name, ".instructionRequest"}, {31'b0, instructionRequest}, {31'b0, expReq});
      compare({name, ".passedPC"}, passedPC, expPassed);
      compare({name, ".stall"}, {31'b0, stall}, {31'b0, fetchRequest && !expValid});
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      fetchRequest = 1'b0; flush = 1'b0; receivedInstruction = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   localparam logic [63:0] LINE_A = 64'h00500113_00300193;
   localparam logic [63:0] LINE_B = 64'hAAAA0001_BBBB0002;
   localparam logic [63:0] LINE_C = 64'h11111111_22222222;
   localparam logic [63:0] LINE_D = 64'h33333333_44444444;
   localparam logic [63:0] LINE_E = 64'h55555555_66666666;
   localparam logic [63:0] LINE_F = 64'h77777777_88888888;
   localparam logic [63:0] STALE  = 64'hDEADBEEF_CAFEF00D;

   initial begin
      reset = 1'b1;
      fetchPC = 32'h0; fetchRequest = 1'b0; flush = 1'b0;
      receivedInstruction = 1'b0; cacheData = 64'h0;

      //          name          req pc     fl recv data    eV eInstr        eReq ePassed
      addVector("coldMiss",     1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("coldReq",      1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("coldFill",     1, 32'h0,  0, 1, LINE_A,  1, 32'h00500113, 0, 32'h0);
      addVector("hitWord1",     1, 32'h4,  0, 0, 64'h0,   1, 32'h00300193, 0, 32'h0);
      addVector("hitWord0",     1, 32'h0,  0, 0, 64'h0,   1, 32'h00500113, 0, 32'h0);
      addVector("conflictMiss", 1, 32'h40, 0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("conflictReq",  1, 32'h40, 0, 0, 64'h0,   0, 32'h0,        1, 32'h40);
      addVector("conflictFill", 1, 32'h40, 0, 1, LINE_B,  1, 32'hAAAA0001, 0, 32'h40);
      addVector("conflictHit",  1, 32'h44, 0, 0, 64'h0,   1, 32'hBBBB0002, 0, 32'h40);
      addVector("evictedMiss",  1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        0, 32'h40);
      addVector("evictedReq",   1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("evictedFill",  1, 32'h0,  0, 1, LINE_A,  1, 32'h00500113, 0, 32'h0);
      addVector("flushIdle",    0, 32'h0,  1, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("flushedMiss",  1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("flushedReq",   1, 32'h0,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("flushedFill",  1, 32'h0,  0, 1, LINE_C,  1, 32'h11111111, 0, 32'h0);
      addVector("hitInFlush",   1, 32'h4,  1, 0, 64'h0,   1, 32'h22222222, 0, 32'h0);
      addVector("afterFlush",   1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("afterFlReq",   1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("flushInWait",  1, 32'h4,  1, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("waitFlFill",   1, 32'h4,  0, 1, LINE_D,  1, 32'h44444444, 0, 32'h0);
      addVector("waitFlRefetch",1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("waitFlReq",    1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("flushOnFill",  1, 32'h4,  1, 1, LINE_E,  1, 32'h66666666, 0, 32'h0);
      addVector("fillFlMiss",   1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        0, 32'h0);
      addVector("fillFlReq",    1, 32'h4,  0, 0, 64'h0,   0, 32'h0,        1, 32'h0);
      addVector("cleanFill",    1, 32'h4,  0, 1, LINE_F,  1, 32'h88888888, 0, 32'h0);
      addVector("cleanHit",     1, 32'h0,  0, 0, 64'h0,   1, 32'h77777777, 0, 32'h0);
      addVector("strayRecv",    0, 32'h0,  0, 1, STALE,   0, 32'h0,        0, 32'h0);
      addVector("notOverwrote", 1, 32'h0,  0, 0, 64'h0,   1, 32'h77777777, 0, 32'h0);

      #3;
      checkOutput("resetState", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vectors[i]) begin
         applyStimulus(vectors[i].req, vectors[i].pc, vectors[i].fl, vectors[i].recv, vectors[i].data);
         checkOutput(vectors[i].name, vectors[i].expValid, vectors[i].expInstr,
                     vectors[i].expReq, vectors[i].expPassed);
      end

      // Reset asserted while waiting for the fill, then a stale fill after release.
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 64'h0);
      checkOutput("midMiss", 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 64'h0);
      checkOutput("midReq", 1'b0, 32'h0, 1'b1, 32'h100);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 64'h0);
      checkOutput("midWait", 1'b0, 32'h0, 1'b0, 32'h100);
      reset = 1'b1;
      fetchRequest = 1'b0;
      #1;
      checkOutput("asyncReset", 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, STALE);
      checkOutput("staleFill", 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 64'h0);
      checkOutput("postRstMiss", 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 64'h0);
      checkOutput("postRstReq", 1'b0, 32'h0, 1'b1, 32'h8);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, LINE_B);
      checkOutput("postRstFill", 1'b1, 32'hAAAA0001, 1'b0, 32'h8);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
      checkOutput("line0Cleared", 1'b0, 32'h0, 1'b0, 32'h8);

      // Fresh reset, then 0x0 0x4 0x8 0xC 0x0: two misses, three hits.
      doReset();
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, LINE_A);
      checkOutput("statFill0", 1'b1, 32'h00500113, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 64'h0);
      checkOutput("statHit4", 1'b1, 32'h00300193, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 64'h0);
      checkOutput("statReq8", 1'b0, 32'h0, 1'b1, 32'h8);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, LINE_C);
      checkOutput("statFill8", 1'b1, 32'h11111111, 1'b0, 32'h8);
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 64'h0);
      checkOutput("statHitC", 1'b1, 32'h22222222, 1'b0, 32'h8);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
      checkOutput("statHit0", 1'b1, 32'h00500113, 1'b0, 32'h8);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      @(posedge clk);
      #1;
`ifdef ICACHE_STATS_EN
      compare("missCount", missCount, 32'd2);
      compare("hitCount", hitCount, 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_cache_controller.md
Name: instruction_cache_controller

Overview:
- Direct-mapped instruction cache sitting between the fetch stage and instruction memory; acts as the initiator of the memory fill protocol.
- Serves fetch hits combinationally in the same cycle.
- On a miss, issues a one-cycle request with the miss address and captures the 64-bit line returned by memory. The requested word is forwarded to fetch in the fill cycle and the line is written into the cache.

Parameters:
- NUM_LINES, 8, number of cache lines. Power of 2, at least 2. Each line holds 2 words (8 bytes).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- fetchPC  input  32  byte address of the instruction to fetch; PC[1:0] ignored
- fetchRequest  input  1  fetch stage wants an instruction; held with fetchPC stable until instructionValid
- flush  input  1  invalidate all lines (fence.i)
- instruction  output  32  fetched instruction; valid only while instructionValid=1
- instructionValid  output  1  instruction is valid this cycle
- stall  output  1  fetchRequest && !instructionValid
- passedPC  output  32  line address sent to memory; low 3 bits are 0
- instructionRequest  output  1  one-cycle fill request to memory
- cacheData  input  64  fill line: [63:32] = word at line base, [31:0] = word at base+4
- receivedInstruction  input  1  cacheData is valid this cycle

Behaviour:
- Address split, with IDX = log2(NUM_LINES):
  - word select = PC[2]
  - index = PC[3+IDX-1:3]
  - tag = PC[31:3+IDX]
- Storage per line: valid bit, tag, 64-bit data. Data and tags are not reset; valid bits clear on reset.
- Reset values: state=IDLE, all valid=0, instructionRequest=0, passedPC=0, instruction=0, instructionValid=0.
- Hit = valid[index] && tag match.
- State IDLE:
  - fetchRequest && hit: instructionValid=1 in the same cycle. instruction = line word selected by PC[2] (0 selects [63:32], 1 selects [31:0]).
  - fetchRequest && miss: register missPC = {fetchPC[31:3],3'b0}; go to REQUEST.
  - instruction=0 whenever instructionValid=0.
- State REQUEST:
  - instructionRequest=1 for exactly one cycle; passedPC=missPC; go to WAIT.
- State WAIT:
  - passedPC is held at missPC; instructionRequest=0.
  - On receivedInstruction: write cacheData and the tag to the line, set valid, go to IDLE.
  - In the same cycle, forward the selected word from cacheData with instructionValid=1.
- Miss latency with the standard memory: miss detected at cycle N, request at N+1, fill and instructionValid at N+2.
- receivedInstruction outside WAIT is ignored. This covers a stale fill that arrives after a reset during a miss.
- flush:
  - Clears all valid bits at the clock edge.
  - A hit in the flush cycle is still served.
  - flush during REQUEST or WAIT: the fill completes and the word is forwarded, but the line is not marked valid.
  - flush coincident with the fill write: flush wins and valid stays 0.
- fetchPC or fetchRequest changing during a miss is illegal. The controller uses missPC and forwards based on the missPC word select.
- Reset mid-operation: immediate return to IDLE; the request is dropped with no retry.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two outputs:
  - hitCount  output  32: increments on each IDLE hit with fetchRequest=1.
  - missCount  output  32: increments on each miss detection, not on the fill cycle.
- Both counters wrap modulo 2^32, reset to 0, and are not cleared by flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, fetchRequest=1, fetchPC=0x0 -> cycle 1 instructionRequest=1 with passedPC=0x0; cycle 2 receivedInstruction with cacheData=0x00500113_00300193 -> instructionValid=1, instruction=0x00500113.
- Line hit: then fetchPC=0x4 -> same-cycle instructionValid=1, instruction=0x00300193, no instructionRequest.
- Conflict eviction (NUM_LINES=8): fetch 0x40 (same index as 0x0, different tag) -> miss and fill; then fetch 0x0 -> miss again.
- Flush: with line 0 valid, pulse flush, then fetch 0x0 -> miss. Separately, flush in WAIT -> word forwarded, and a refetch of the same PC misses.
- Reset mid-miss: assert reset in WAIT; stale receivedInstruction 1 cycle after release -> ignored, instructionValid=0, next fetch 0x8 -> miss with passedPC=0x8.
- Stats (ICACHE_STATS_EN): sequence 0x0, 0x4, 0x8, 0xC, 0x0 -> missCount=2, hitCount=3.
